lt24_pixel_writer: RTL and testbench
====================================

LT24_PIXEL_WRITER -- requirements
Module: lt24_pixel_writer

Interface
REQ-001 SHALL have parameter WR_LOW_CYCLES, default 1, meaning the number of clock cycles LT24Wr_n is held low per bus write (range 1..15).
REQ-002 SHALL have parameter WR_HIGH_CYCLES, default 1, meaning the number of clock cycles LT24Wr_n is held high after each low phase (range 1..15).
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 xAddr  input  8  pixel column, valid range 0..239.
REQ-006 yAddr  input  9  pixel row, valid range 0..319.
REQ-007 pixelData  input  16  RGB565 pixel value.
REQ-008 pixelWrite  input  1  pixel request; qualified by pixelReady.
REQ-009 pixelReady  output  1  block can accept a pixel this cycle.
REQ-010 LT24CS_n  output  1  LCD chip select, active low.
REQ-011 LT24RS  output  1  0 = command word, 1 = data word.
REQ-012 LT24Wr_n  output  1  LCD write strobe, active low; data is latched by the LCD on its rising edge.
REQ-013 LT24Rd_n  output  1  LCD read strobe; SHALL be held constantly at 1.
REQ-014 LT24Data  output  16  LCD data bus.

Function
REQ-015 A pixel SHALL be accepted on a rising edge where pixelWrite=1 and pixelReady=1; xAddr, yAddr and pixelData SHALL be captured on that edge.
REQ-016 pixelReady SHALL be 1 only in state IDLE and SHALL drop on the cycle after acceptance.
REQ-017 A pixel with xAddr>239 or yAddr>319 SHALL be accepted and discarded: no bus activity, pixelReady stays 1, and the expected-address tracker is unchanged.
REQ-018 Every bus write SHALL follow the same timing:
  - LT24RS and LT24Data are stable for the whole write.
  - LT24Wr_n is 0 for WR_LOW_CYCLES cycles, then 1 for WR_HIGH_CYCLES cycles.
REQ-019 The block SHALL hold an expected-next address (EX,EY) and a flag winValid; both are cleared by reset.
REQ-020 If winValid=1 and the captured (x,y) equals (EX,EY), the block SHALL issue exactly one data write (RS=1, Data=pixelData).
REQ-021 Otherwise the block SHALL issue this 12-write window sequence, then set winValid=1:
  - cmd 0x002A; data 0x00,x[7:0]; data 0x0000, 0x00EF;
  - cmd 0x002B; data {7'b0,y[8]} in bits 7:0, then y[7:0]; data 0x0001, 0x003F;
  - cmd 0x002C; data pixelData.
REQ-022 Command words SHALL drive RS=0, data words RS=1; all byte-valued words SHALL have LT24Data[15:8]=0.
REQ-023 State machine states: IDLE, CMD_COL, COL_D0..COL_D3, CMD_PAGE, PAGE_D0..PAGE_D3, CMD_MEMWR, PIXEL.
  - IDLE goes to PIXEL on a sequential accept, to CMD_COL on a non-sequential accept.
  - The window sequence steps in the order of REQ-021 into PIXEL.
  - PIXEL returns to IDLE after its high phase completes.
REQ-024 After each pixel write the tracker SHALL advance:
  - normally EX=x+1, EY=y;
  - if x=239: EX=0, EY=y+1;
  - if x=239 and y=319: EX=0, EY=0.
REQ-025 LT24CS_n SHALL be 0 from the first bus write of a transaction through its final high phase, and 1 in IDLE.
REQ-026 pixelReady SHALL return to 1 in the cycle following the final high phase, so sequential throughput is 1+WR_LOW_CYCLES+WR_HIGH_CYCLES cycles per pixel.
REQ-027 A full window transaction SHALL take 1+12*(WR_LOW_CYCLES+WR_HIGH_CYCLES) cycles from the accept edge to pixelReady=1.
REQ-028 pixelWrite asserted while pixelReady=0 SHALL be ignored and not queued.

Reset
REQ-029 While reset=1 the outputs SHALL be:
  - pixelReady=0, LT24CS_n=1, LT24Wr_n=1, LT24Rd_n=1, LT24RS=1, LT24Data=0;
  - state=IDLE, winValid=0, EX=0, EY=0.
REQ-030 pixelReady SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-transaction SHALL abort it on that edge with no further Wr_n strobes, and the next pixel SHALL issue a full window sequence.

Verification (defaults L=H=1)
REQ-032 Pixel (0,0,0xF800) after reset -> 12 writes: 2A,00,00,00,EF,2B,00,00,01,3F,2C (RS=0 on 2A/2B/2C), then F800 with RS=1; pixelReady returns 25 cycles after accept.
REQ-033 Next pixel (1,0,0x07E0) -> exactly one data write 07E0, RS=1; pixelReady returns 3 cycles after accept.
REQ-034 Pixel (239,5), then (0,6) -> the second pixel produces a single data write with no commands; then (10,6) -> full window sequence with column data 00,0A and page data 00,06.
REQ-035 Pixel (240,10) or (0,320) -> no Wr_n strobe and LT24CS_n stays 1; the following pixel (EX,EY) is still a single data write.
REQ-036 Reset pulsed during COL_D2 -> Wr_n=1 and CS_n=1 from the next cycle; the next pixel (2,0) emits a full window sequence.
REQ-037 pixelWrite held at 1 continuously across a raster of 4 sequential pixels -> exactly 4 data writes, one per accept, and no duplicates.

Source files
------------

// File: rtl/lt24_pixel_writer.sv
// lt24_pixel_writer: writes pixels (xAddr,yAddr,pixelData via pixelWrite/pixelReady) to an LT24 LCD bus (LT24CS_n/RS/Wr_n/Rd_n/Data), re-sending the window only for non-sequential pixels
module lt24_pixel_writer #(
  parameter int WR_LOW_CYCLES  = 1,
  parameter int WR_HIGH_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic [15:0] LT24Data
);
  typedef enum logic [3:0] {
    IDLE, CMD_COL, COL_D0, COL_D1, COL_D2, COL_D3,
    CMD_PAGE, PAGE_D0, PAGE_D1, PAGE_D2, PAGE_D3, CMD_MEMWR, PIXEL
  } state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        setup_q, win_q, ready_q, cs_q, rs_q, wr_q;
  logic [7:0]  x_q, ex_q, ex_d;
  logic [8:0]  y_q, ey_q, ey_d;
  logic [15:0] pix_q, data_q;
  logic        in_range, seq, last;
  state_t      start_s, next_s;
  function automatic logic [16:0] word(state_t s, logic [7:0] x, logic [8:0] y, logic [15:0] p);
    case (s)
      CMD_COL:   word = {1'b0, 16'h002A};
      COL_D1:    word = {9'h100, x};
      COL_D3:    word = {1'b1, 16'h00EF};
      CMD_PAGE:  word = {1'b0, 16'h002B};
      PAGE_D0:   word = {1'b1, 15'h0, y[8]};
      PAGE_D1:   word = {9'h100, y[7:0]};
      PAGE_D2:   word = {1'b1, 16'h0001};
      PAGE_D3:   word = {1'b1, 16'h003F};
      CMD_MEMWR: word = {1'b0, 16'h002C};
      PIXEL:     word = {1'b1, p};
      default:   word = {1'b1, 16'h0000};
    endcase
  endfunction
  assign in_range = (xAddr <= 8'd239) && (yAddr <= 9'd319);
  assign seq      = win_q && xAddr == ex_q && yAddr == ey_q;
  assign start_s  = seq ? PIXEL : CMD_COL;
  assign next_s   = state_t'(state_q + 4'd1);
  assign last     = cnt_q == 5'(WR_LOW_CYCLES + WR_HIGH_CYCLES - 1);
  assign ex_d     = x_q == 8'd239 ? 8'd0 : x_q + 8'd1;
  assign ey_d     = x_q != 8'd239 ? y_q : (y_q == 9'd319 ? 9'd0 : y_q + 9'd1);
  assign pixelReady = ready_q & ~reset;
  assign LT24CS_n   = cs_q;
  assign LT24RS     = rs_q;
  assign LT24Wr_n   = wr_q;
  assign LT24Rd_n   = 1'b1;
  assign LT24Data   = data_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      setup_q <= 1'b0;
      win_q   <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
      ready_q <= 1'b1;
      cs_q    <= 1'b1;
      rs_q    <= 1'b1;
      wr_q    <= 1'b1;
      data_q  <= '0;
    end else if (state_q == IDLE) begin
      if (ready_q && pixelWrite && in_range) begin
        x_q     <= xAddr;
        y_q     <= yAddr;
        pix_q   <= pixelData;
        state_q <= start_s;
        ready_q <= 1'b0;
        cs_q    <= 1'b0;
        setup_q <= 1'b1;
        cnt_q   <= '0;
        {rs_q, data_q} <= word(start_s, xAddr, yAddr, pixelData);
      end
    end else if (setup_q) begin
      setup_q <= 1'b0;
      wr_q    <= 1'b0;
    end else if (!last) begin
      cnt_q <= cnt_q + 5'd1;
      wr_q  <= cnt_q >= 5'(WR_LOW_CYCLES - 1);
    end else if (state_q == PIXEL) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      cs_q    <= 1'b1;
      win_q   <= 1'b1;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
    end else begin
      state_q <= next_s;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      {rs_q, data_q} <= word(next_s, x_q, y_q, pix_q);
    end
  end
endmodule

// File: tb/tb_lt24_pixel_writer.sv
// tb_lt24_pixel_writer: scoreboard bench comparing LT24 bus words and pixelReady latency with a raster-index reference model
module tb_lt24_pixel_writer;
  localparam int L = 1;
  localparam int H = 1;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady, LT24CS_n, LT24RS, LT24Wr_n, LT24Rd_n;
  logic [15:0] LT24Data;
  lt24_pixel_writer #(.WR_LOW_CYCLES(L), .WR_HIGH_CYCLES(H)) dut (
    .clock(clock), .reset(reset), .xAddr(xAddr), .yAddr(yAddr),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .LT24CS_n(LT24CS_n), .LT24RS(LT24RS), .LT24Wr_n(LT24Wr_n),
    .LT24Rd_n(LT24Rd_n), .LT24Data(LT24Data)
  );
  always #5 clock = ~clock;
  int pass_n = 0;
  int total_n = 0;
  logic [16:0] exp_q[$];
  int ex = 0, ey = 0, exp_lat = 0;
  bit wv = 1'b0;
  task automatic check(string name, int act, int req);
    total_n++;
    if (act == req) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask
  task automatic predict(int x, int y, logic [15:0] p);
    int idx;
    if (x > 239 || y > 319) begin
      exp_lat = 0;
      return;
    end
    if (wv && x == ex && y == ey) begin
      exp_q.push_back({1'b1, p});
      exp_lat = 1 + L + H;
    end else begin
      exp_q.push_back({1'b0, 16'h002A});
      exp_q.push_back({1'b1, 16'h0000});
      exp_q.push_back({1'b1, 16'(x)});
      exp_q.push_back({1'b1, 16'h0000});
      exp_q.push_back({1'b1, 16'h00EF});
      exp_q.push_back({1'b0, 16'h002B});
      exp_q.push_back({1'b1, 16'(y / 256)});
      exp_q.push_back({1'b1, 16'(y % 256)});
      exp_q.push_back({1'b1, 16'h0001});
      exp_q.push_back({1'b1, 16'h003F});
      exp_q.push_back({1'b0, 16'h002C});
      exp_q.push_back({1'b1, p});
      exp_lat = 1 + 12 * (L + H);
    end
    idx = (y * 240 + x + 1) % (240 * 320);
    ex = idx % 240;
    ey = idx / 240;
    wv = 1'b1;
  endtask
  task automatic accept_px(int x, int y, logic [15:0] p, bit hold);
    int n = 0;
    while (!pixelReady && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check("ready_before_accept", int'(pixelReady), 1);
    xAddr = 8'(x);
    yAddr = 9'(y);
    pixelData = p;
    pixelWrite = 1'b1;
    @(posedge clock);
    predict(x, y, p);
    #1;
    if (!hold) pixelWrite = 1'b0;
  endtask
  task automatic measure(string nm, bit hold);
    int n = 0;
    while (!pixelReady && n < 1000) begin
      if (hold) begin
        xAddr = 8'($urandom);
        yAddr = 9'($urandom);
        pixelData = 16'($urandom);
      end
      @(posedge clock); #1;
      n++;
    end
    check(nm, n, exp_lat);
    if (exp_lat == 0) check({nm, "_cs_idle"}, int'(LT24CS_n), 1);
  endtask
  task automatic send(string nm, int x, int y, logic [15:0] p, bit hold = 1'b0);
    accept_px(x, y, p, hold);
    measure(nm, hold);
  endtask
  task automatic check_reset_outputs(string nm);
    check({nm, "_ready"}, int'(pixelReady), 0);
    check({nm, "_cs_n"}, int'(LT24CS_n), 1);
    check({nm, "_wr_n"}, int'(LT24Wr_n), 1);
    check({nm, "_rd_n"}, int'(LT24Rd_n), 1);
    check({nm, "_rs"}, int'(LT24RS), 1);
    check({nm, "_data"}, int'(LT24Data), 0);
  endtask
  logic wr_prev = 1'b1;
  int low_n = 0;
  always @(negedge clock) begin
    if (reset) begin
      low_n = 0;
    end else if (!LT24Wr_n) begin
      if (wr_prev) begin
        check("queue_has_word_at_low", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("word_at_low", int'({LT24RS, LT24Data}), int'(exp_q[0]));
      end
      low_n++;
      check("rd_n_high", int'(LT24Rd_n), 1);
    end else if (!wr_prev) begin
      check("queue_has_word_at_rise", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("word_at_rise", int'({LT24RS, LT24Data}), int'(exp_q.pop_front()));
      check("low_len", low_n, L);
      check("cs_during_write", int'(LT24CS_n), 0);
      low_n = 0;
    end
    wr_prev = LT24Wr_n;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int r, x, y;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    #1;
    check("ready_after_reset", int'(pixelReady), 1);
    send("first_window", 0, 0, 16'hF800);
    send("seq_pixel", 1, 0, 16'h07E0);
    send("row_end", 239, 5, 16'h1234);
    send("row_wrap_seq", 0, 6, 16'h5678);
    send("jump_window", 10, 6, 16'h9ABC);
    send("bad_x", 240, 10, 16'hDEAD);
    send("bad_y", 0, 320, 16'hBEEF);
    send("seq_after_bad", 11, 6, 16'h0F0F);
    send("last_pixel", 239, 319, 16'hAAAA);
    send("frame_wrap_seq", 0, 0, 16'h5555);
    accept_px(5, 5, 16'h3333, 1'b0);
    repeat (1 + 2 * 3) @(posedge clock);
    #1;
    check("in_col_d2_low", int'(LT24Wr_n), 0);
    reset = 1'b1;
    exp_q.delete();
    wv = 1'b0;
    ex = 0;
    ey = 0;
    @(posedge clock); #1;
    check_reset_outputs("abort");
    @(posedge clock); #1;
    check("abort_wr_n_hold", int'(LT24Wr_n), 1);
    reset = 1'b0;
    send("post_abort_window", 2, 0, 16'h4444);
    send("hold_seq0", 3, 0, 16'h1001, 1'b1);
    send("hold_seq1", 4, 0, 16'h1002, 1'b1);
    send("hold_seq2", 5, 0, 16'h1003, 1'b1);
    send("hold_seq3", 6, 0, 16'h1004, 1'b1);
    pixelWrite = 1'b0;
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        x = ex;
        y = ey;
      end else if (r < 6) begin
        x = $urandom_range(0, 1) ? $urandom_range(240, 255) : $urandom_range(0, 239);
        y = x > 239 ? $urandom_range(0, 319) : $urandom_range(320, 511);
      end else begin
        x = $urandom_range(0, 239);
        y = $urandom_range(0, 319);
      end
      send("random_pixel", x, y, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    pixelWrite = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
